// File: rtl/shift_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : shift_port_arbiter                                         |
// | Description : Round-robin front end for one shared combinational         |
// |               bi-directional spike shifter. Grants one of NREQ           |
// |               requesters and registers its spike vector and one-hot      |
// |               shift select toward the shifter. Captures the shifter      |
// |               result one cycle later and returns it on a valid/ready     |
// |               response channel tagged with the requester id.             |
// | Ports       : clk, rst_n (sync, active-low)                              |
// |               req_valid/req_ready/req_ip/req_shift : request side        |
// |               sh_ip/sh_mag -> shifter operands, sh_op <- shifter result  |
// |               rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err : response     |
// | Options     : SHIFT_PORT_SAT_EN - clamp out-of-range shifts to           |
// |               +/-MAX_SHIFT_MAG instead of selecting nothing.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module shift_port_arbiter #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int NREQ          = 4,
    parameter int SW            = $clog2(MAX_SHIFT_MAG) + 2,
    parameter int IDW           = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*LEN-1:0]        req_ip,
    input  logic [NREQ*SW-1:0]         req_shift,
    output logic [LEN-1:0]             sh_ip,
    output logic [2*MAX_SHIFT_MAG:0]   sh_mag,
    input  logic [LEN-1:0]             sh_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [LEN-1:0]             rsp_data,
    output logic [IDW-1:0]             rsp_id,
    output logic                       rsp_err
);

    localparam int c_mag_w = 2 * MAX_SHIFT_MAG + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id_q;
    logic               r_err_q;

    logic               w_any_req;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW:0]       w_cand_sum;
    logic [IDW-1:0]     w_cand;
    logic               w_rsp_accept;
    logic               w_window;
    logic               w_gnt_fire;
    logic [IDW-1:0]     w_rr_next;
    logic [LEN-1:0]     w_gnt_ip;
    logic [SW-1:0]      w_gnt_shift;
    int                 w_shift_val;
    int                 w_sel_val;
    logic               w_range_err;
    logic [c_mag_w-1:0] w_mag;

    assign w_rsp_accept = (r_state == ST_RESP) && rsp_ready;
    // A new grant may overlap the cycle in which the previous response is taken.
    assign w_window     = (r_state == ST_IDLE) || w_rsp_accept;
    assign w_gnt_fire   = rst_n && w_window && w_any_req;
    assign w_rr_next    = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Round-robin search starting at r_rr_ptr; the candidate index is wrapped
    // by subtraction so NREQ need not be a power of two.
    always_comb begin
        w_any_req  = 1'b0;
        w_gnt_idx  = '0;
        w_cand_sum = '0;
        w_cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand_sum = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (w_cand_sum >= (IDW+1)'(NREQ)) begin
                w_cand_sum = w_cand_sum - (IDW+1)'(NREQ);
            end
            w_cand = w_cand_sum[IDW-1:0];
            if (!w_any_req && req_valid[w_cand]) begin
                w_any_req = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt_ip    = '0;
        w_gnt_shift = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_idx == IDW'(k)) begin
                w_gnt_ip    = req_ip[k*LEN +: LEN];
                w_gnt_shift = req_shift[k*SW +: SW];
            end
        end
    end

    // Select position s+MAX_SHIFT_MAG counted from the MSB, i.e. bit
    // MAX_SHIFT_MAG-s of the descending vector. An unclamped out-of-range
    // value matches no position and leaves the select all zero.
    always_comb begin
        w_shift_val = int'($signed(w_gnt_shift));
        w_range_err = (w_shift_val > MAX_SHIFT_MAG) || (w_shift_val < -MAX_SHIFT_MAG);
`ifdef SHIFT_PORT_SAT_EN
        if (w_shift_val > MAX_SHIFT_MAG) begin
            w_sel_val = MAX_SHIFT_MAG;
        end else if (w_shift_val < -MAX_SHIFT_MAG) begin
            w_sel_val = -MAX_SHIFT_MAG;
        end else begin
            w_sel_val = w_shift_val;
        end
`else
        w_sel_val = w_shift_val;
`endif
        w_mag = '0;
        for (int b = 0; b < c_mag_w; b++) begin
            if (w_sel_val == MAX_SHIFT_MAG - b) begin
                w_mag[b] = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_fire && (w_gnt_idx == IDW'(k))) begin
                req_ready[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_fire) w_state_next = ST_SHIFT;
            ST_SHIFT: w_state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_next = w_gnt_fire ? ST_SHIFT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shifter operands move only on a grant (or back to a zero select when the
    // block goes idle), keeping sh_op steady through the SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_id_q    <= '0;
            r_err_q   <= 1'b0;
            sh_ip     <= '0;
            sh_mag    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_gnt_fire) begin
                sh_ip    <= w_gnt_ip;
                sh_mag   <= w_mag;
                r_err_q  <= w_range_err;
                r_id_q   <= w_gnt_idx;
                r_rr_ptr <= w_rr_next;
            end else if (w_rsp_accept) begin
                sh_mag   <= '0;
            end

            if (r_state == ST_SHIFT) begin
                rsp_data  <= sh_op;
                rsp_id    <= r_id_q;
                rsp_err   <= r_err_q;
                rsp_valid <= 1'b1;
            end else if (w_rsp_accept) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_shift_port_arbiter                                      |
// | Description : Self-checking bench for shift_port_arbiter. Provides a     |
// |               wrap-around shared shifter, a vector table, hand-written   |
// |               multi-cycle sequences and a randomized scoreboard run.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_shift_port_arbiter;

    localparam int LEN           = 8;
    localparam int MAX_SHIFT_MAG = 2;
    localparam int NREQ          = 4;
    localparam int SW            = $clog2(MAX_SHIFT_MAG) + 2;
    localparam int IDW           = $clog2(NREQ);
    localparam int MW            = 2 * MAX_SHIFT_MAG + 1;
    localparam int NV            = 9;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*LEN-1:0]  req_ip;
    logic [NREQ*SW-1:0]   req_shift;
    logic [LEN-1:0]       sh_ip;
    logic [MW-1:0]        sh_mag;
    logic [LEN-1:0]       sh_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [LEN-1:0]       rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int             id;
        logic [LEN-1:0] ip;
        int             shift;
        logic [LEN-1:0] exp_data;
        logic           exp_err;
        logic [MW-1:0]  exp_mag;
    } vec_t;

    typedef struct {
        int             id;
        logic [LEN-1:0] data;
        logic           err;
    } exp_t;

    vec_t vecs[NV];

    shift_port_arbiter #(
        .LEN           (LEN),
        .MAX_SHIFT_MAG (MAX_SHIFT_MAG),
        .NREQ          (NREQ),
        .SW            (SW),
        .IDW           (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ip    (req_ip),
        .req_shift (req_shift),
        .sh_ip     (sh_ip),
        .sh_mag    (sh_mag),
        .sh_op     (sh_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time t lives at conventional bit t, so a delay of n is a rotate left by n.
    function automatic logic [LEN-1:0] rotl(input logic [LEN-1:0] v, input int n);
        int m;
        m = ((n % LEN) + LEN) % LEN;
        return (v << m) | (v >> (LEN - m));
    endfunction

    // Shared shifter: select position p (from MSB) means shift p-MAX_SHIFT_MAG.
    always_comb begin
        sh_op = '0;
        for (int b = 0; b < MW; b++) begin
            if (sh_mag[b]) sh_op = sh_op | rotl(sh_ip, MAX_SHIFT_MAG - b);
        end
    end

    function automatic logic ref_err(input int s);
        return (s > MAX_SHIFT_MAG) || (s < -MAX_SHIFT_MAG);
    endfunction

    function automatic logic [LEN-1:0] ref_data(input logic [LEN-1:0] ip, input int s);
        int             eff;
        logic [LEN-1:0] r;
        r   = '0;
        eff = s;
        if (ref_err(s)) begin
`ifdef SHIFT_PORT_SAT_EN
            eff = (s > 0) ? MAX_SHIFT_MAG : -MAX_SHIFT_MAG;
`else
            return '0;
`endif
        end
        for (int t = 0; t < LEN; t++) begin
            if (ip[t]) r = r | (LEN'(1) << (((t + eff) % LEN + LEN) % LEN));
        end
        return r;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int k);
        return NREQ'(1) << k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
    endtask

    task automatic set_req(input int k, input logic [LEN-1:0] ip, input int s);
        req_valid[k]             = 1'b1;
        req_ip[k*LEN +: LEN]     = ip;
        req_shift[k*SW +: SW]    = SW'(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [LEN-1:0] rr_ip [NREQ];
        int             rr_sh [NREQ];
        bit             pend  [NREQ];
        logic [LEN-1:0] pip   [NREQ];
        int             psh   [NREQ];
        exp_t           q[$];
        exp_t           e;
        int             ptr;
        int             age;
        int             g;
        int             idx;
        bit             busy;
        bit             exp_v;
        bit             window;

        vecs[0] = '{0, 8'b0000_0010,  1, 8'b0000_0100, 1'b0, 5'b00010};
        vecs[1] = '{2, 8'b0100_0000,  2, 8'b0000_0001, 1'b0, 5'b00001};
        vecs[2] = '{2, 8'b0000_0001, -1, 8'b1000_0000, 1'b0, 5'b01000};
        vecs[3] = '{1, 8'b1010_0101,  0, 8'b1010_0101, 1'b0, 5'b00100};
        vecs[4] = '{3, 8'b0001_1000, -2, 8'b0000_0110, 1'b0, 5'b10000};
        vecs[5] = '{3, 8'b1100_0000,  1, 8'b1000_0001, 1'b0, 5'b00010};
`ifdef SHIFT_PORT_SAT_EN
        vecs[6] = '{0, 8'b0000_0010,  3, 8'b0000_1000, 1'b1, 5'b00001};
        vecs[7] = '{1, 8'b1000_0001, -4, 8'b0110_0000, 1'b1, 5'b10000};
        vecs[8] = '{2, 8'b0000_0011, -3, 8'b1100_0000, 1'b1, 5'b10000};
`else
        vecs[6] = '{0, 8'b0000_0010,  3, 8'b0000_0000, 1'b1, 5'b00000};
        vecs[7] = '{1, 8'b1000_0001, -4, 8'b0000_0000, 1'b1, 5'b00000};
        vecs[8] = '{2, 8'b0000_0011, -3, 8'b0000_0000, 1'b1, 5'b00000};
`endif

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        req_ip    = '0;
        req_shift = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sh_ip",     32'(sh_ip),     32'd0);
        check("rst_sh_mag",    32'(sh_mag),    32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        rst_n     = 1'b1;
        clear_reqs();
        rsp_ready = 1'b1;
        @(negedge clk);

        // ---------------- round-robin, all requesters valid ----------------
        rr_ip = '{8'h03, 8'h30, 8'h81, 8'h42};
        rr_sh = '{1, -1, 2, -2};
        for (int k = 0; k < NREQ; k++) set_req(k, rr_ip[k], rr_sh[k]);
        for (int c = 0; c <= 10; c++) begin
            if (c == 9) clear_reqs();
            #1;
            if (c >= 2 && c % 2 == 0) begin
                check("rr_valid", 32'(rsp_valid), 32'd1);
                check("rr_id",    32'(rsp_id),    32'((c / 2 - 1) % NREQ));
                check("rr_data",  32'(rsp_data),
                      32'(ref_data(rr_ip[(c / 2 - 1) % NREQ], rr_sh[(c / 2 - 1) % NREQ])));
            end else begin
                check("rr_valid_gap", 32'(rsp_valid), 32'd0);
            end
            if (c % 2 == 0 && c <= 8) check("rr_ready", 32'(req_ready), 32'(oh((c / 2) % NREQ)));
            else                      check("rr_ready_idle", 32'(req_ready), 32'd0);
            @(negedge clk);
        end

        // ---------------- vector table, single requester each ----------------
        for (int i = 0; i < NV; i++) begin
            clear_reqs();
            rsp_ready = 1'b1;
            set_req(vecs[i].id, vecs[i].ip, vecs[i].shift);
            #1;
            check("tbl_ready", 32'(req_ready), 32'(oh(vecs[i].id)));
            @(negedge clk);
            clear_reqs();
            #1;
            check("tbl_mag",        32'(sh_mag),    32'(vecs[i].exp_mag));
            check("tbl_shift_gap",  32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1;
            check("tbl_valid", 32'(rsp_valid), 32'd1);
            check("tbl_data",  32'(rsp_data),  32'(vecs[i].exp_data));
            check("tbl_id",    32'(rsp_id),    32'(vecs[i].id));
            check("tbl_err",   32'(rsp_err),   32'(vecs[i].exp_err));
            @(negedge clk);
            #1;
            check("tbl_idle_valid", 32'(rsp_valid), 32'd0);
            check("tbl_idle_mag",   32'(sh_mag),    32'd0);
            @(negedge clk);
        end

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        clear_reqs();
        set_req(0, 8'h24, 1);
        #1;
        check("bp_first_ready", 32'(req_ready), 32'(oh(0)));
        @(negedge clk);
        clear_reqs();
        set_req(1, 8'h81, -1);
        #1;
        check("bp_shift_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data",  32'(rsp_data),  32'(ref_data(8'h24, 1)));
            check("bp_hold_id",    32'(rsp_id),    32'd0);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'(oh(1)));
        @(negedge clk);
        clear_reqs();
        #1;
        check("bp_gap_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("bp_r1_valid", 32'(rsp_valid), 32'd1);
        check("bp_r1_id",    32'(rsp_id),    32'd1);
        check("bp_r1_data",  32'(rsp_data),  32'(ref_data(8'h81, -1)));
        @(negedge clk);

        // ---------------- reset during SHIFT ----------------
        clear_reqs();
        set_req(1, 8'h0F, 2);
        #1;
        check("rm_grant", 32'(req_ready), 32'(oh(1)));
        @(negedge clk);
        clear_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        set_req(1, 8'hF0, 0);
        set_req(3, 8'h01, 1);
        #1;
        check("rm_valid", 32'(rsp_valid), 32'd0);
        check("rm_mag",   32'(sh_mag),    32'd0);
        check("rm_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm_first_grant", 32'(req_ready), 32'(oh(1)));
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        #1;
        check("rm_rsp_id",   32'(rsp_id),   32'd1);
        check("rm_rsp_data", 32'(rsp_data), 32'(ref_data(8'hF0, 0)));
        @(negedge clk);

        // ---------------- randomized run against a transaction model ----------------
        do_reset();
        ptr  = 0;
        busy = 1'b0;
        age  = 0;
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0;
            pip[k]  = '0;
            psh[k]  = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k] = 1'b1;
                    pip[k]  = LEN'($urandom);
                    psh[k]  = int'($urandom_range(2**SW - 1)) - 2**(SW - 1);
                end
                req_valid[k]          = pend[k];
                req_ip[k*LEN +: LEN]  = pip[k];
                req_shift[k*SW +: SW] = SW'(psh[k]);
            end
            rsp_ready = ($urandom_range(9) < 7);
            #1;
            exp_v = busy && (age >= 2);
            check("rnd_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v) begin
                check("rnd_id",   32'(rsp_id),   32'(q[0].id));
                check("rnd_data", 32'(rsp_data), 32'(q[0].data));
                check("rnd_err",  32'(rsp_err),  32'(q[0].err));
            end
            window = !busy || (exp_v && rsp_ready);
            g = -1;
            if (window) begin
                for (int i = 0; i < NREQ; i++) begin
                    idx = (ptr + i) % NREQ;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            check("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(oh(g)) : 32'd0);
            if (exp_v && rsp_ready) begin
                busy = 1'b0;
                void'(q.pop_front());
            end
            if (g >= 0) begin
                e.id   = g;
                e.data = ref_data(pip[g], psh[g]);
                e.err  = ref_err(psh[g]);
                q.push_back(e);
                busy    = 1'b1;
                age     = 1;
                ptr     = (g + 1) % NREQ;
                pend[g] = 1'b0;
            end else if (busy) begin
                age++;
            end
            @(negedge clk);
        end
        clear_reqs();
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
